xgmii_reset_seq: RTL
====================

XGMII_RESET_SEQ -- requirements
Module: xgmii_reset_seq

Interface
REQ-001 Parameter PCS_HOLD, default 16: cycles rst_pcs is held after entry to HOLD.
REQ-002 Parameter MAC_DELAY, default 8: cycles of stable link before rst_mac releases.
REQ-003 Parameter APP_DELAY, default 8: cycles after rst_mac release before rst_app releases.
REQ-004 Parameter LINK_TIMEOUT, default 1024: cycles allowed in WAIT_LINK for link_ok.
REQ-005 Parameter MAX_RETRY, default 3: consecutive link timeouts before FAULT.
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high block reset.
REQ-008 soft_rst_req  input  1  single-cycle request to restart the sequence.
REQ-009 link_ok  input  1  PCS block-lock/link indication, already synchronous to clk.
REQ-010 rst_pcs  output  1  active-high reset to XGMII PCS.
REQ-011 rst_mac  output  1  active-high reset to MAC TX/RX.
REQ-012 rst_app  output  1  active-high reset to application logic.
REQ-013 ready  output  1  high only in RUN.
REQ-014 fault  output  1  high only in FAULT.
REQ-015 seq_state  output  3  current state code.
REQ-016 retry_cnt  output  2  consecutive timeout count.

Function
REQ-017 State codes SHALL be HOLD=0, WAIT_LINK=1, MAC_DLY=2, APP_DLY=3, RUN=4, FAULT=5; codes 6-7 SHALL go to HOLD next cycle.
REQ-018 All outputs SHALL be registered and change on the same edge as the state transition that implies them.
REQ-019 One shared cycle counter, width clog2 of the largest delay parameter, SHALL clear to 0 on every state transition.
REQ-020 HOLD: rst_pcs=rst_mac=rst_app=1; after PCS_HOLD cycles in HOLD go to WAIT_LINK with rst_pcs=0.
REQ-021 WAIT_LINK: link_ok=1 -> MAC_DLY; counter reaching LINK_TIMEOUT-1 with link_ok=0 -> timeout.
REQ-022 Timeout: if retry_cnt==MAX_RETRY-1 go to FAULT (retry_cnt unchanged), else retry_cnt+1 and go to HOLD (rst_pcs=1).
REQ-023 link_ok=1 in the timeout cycle SHALL win: go to MAC_DLY, no retry increment.
REQ-024 MAC_DLY: after MAC_DELAY consecutive cycles with link_ok=1 go to APP_DLY with rst_mac=0.
REQ-025 APP_DLY: after APP_DELAY cycles go to RUN with rst_app=0, ready=1, retry_cnt=0.
REQ-026 link_ok=0 in MAC_DLY, APP_DLY or RUN: next edge go to WAIT_LINK, rst_mac=rst_app=1, ready=0, rst_pcs stays 0, retry_cnt unchanged.
REQ-027 FAULT: all three resets=1, fault=1; only soft_rst_req or reset exits.
REQ-028 soft_rst_req=1 in any state: next edge go to HOLD, all resets=1, retry_cnt=0, fault=0, ready=0.
REQ-029 Priority per cycle: reset > soft_rst_req > link loss > link_ok acceptance > timeout/counter expiry.
REQ-030 Release order SHALL always be rst_pcs, then rst_mac, then rst_app; no output SHALL release out of order.

Reset
REQ-031 While reset=1: seq_state=HOLD, counter=0, retry_cnt=0, rst_pcs=rst_mac=rst_app=1, ready=0, fault=0.
REQ-032 Reset asserted mid-sequence SHALL take effect at the next edge regardless of state; first cycle after release counts as HOLD cycle 1.

Verification (PCS_HOLD=16, MAC_DELAY=8, APP_DELAY=8, LINK_TIMEOUT=64, MAX_RETRY=3)
REQ-033 reset low at cycle 0, link_ok=1 throughout -> rst_pcs falls after 16 cycles, rst_mac after 8 further cycles plus the one-cycle WAIT_LINK acceptance, rst_app 8 later, ready=1 thereafter.
REQ-034 link_ok=0 forever -> three 64-cycle WAIT_LINK windows, retry_cnt 0->1->2, then FAULT with fault=1, all resets high.
REQ-035 In RUN drop link_ok for 1 cycle -> next edge rst_mac=rst_app=1, ready=0, state WAIT_LINK, rst_pcs=0; link_ok back -> RUN again after 17 cycles.
REQ-036 In FAULT pulse soft_rst_req -> next edge HOLD, fault=0, retry_cnt=0; normal sequence follows.
REQ-037 link_ok rising exactly on WAIT_LINK counter=63 -> MAC_DLY, retry_cnt unchanged.
REQ-038 Assert reset during APP_DLY -> next edge all outputs at REQ-031 values.

Source files
------------

// File: rtl/xgmii_reset_seq.sv
// rtl/xgmii_reset_seq.sv - staged PCS/MAC/application reset sequencer for an XGMII link
module xgmii_reset_seq #(
  parameter int PCS_HOLD     = 16,
  parameter int MAC_DELAY    = 8,
  parameter int APP_DELAY    = 8,
  parameter int LINK_TIMEOUT = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       soft_rst_req,
  input  logic       link_ok,
  output logic       rst_pcs,
  output logic       rst_mac,
  output logic       rst_app,
  output logic       ready,
  output logic       fault,
  output logic [2:0] seq_state,
  output logic [1:0] retry_cnt
);

  localparam int MAX_A = (PCS_HOLD > MAC_DELAY) ? PCS_HOLD : MAC_DELAY;
  localparam int MAX_B = (APP_DELAY > LINK_TIMEOUT) ? APP_DELAY : LINK_TIMEOUT;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = ($clog2(MAX_D) < 1) ? 1 : $clog2(MAX_D);

  localparam logic [CW-1:0] PCS_LAST  = CW'(PCS_HOLD - 1);
  localparam logic [CW-1:0] MAC_LAST  = CW'(MAC_DELAY - 1);
  localparam logic [CW-1:0] APP_LAST  = CW'(APP_DELAY - 1);
  localparam logic [CW-1:0] LINK_LAST = CW'(LINK_TIMEOUT - 1);
  localparam logic [1:0]    RETRY_LAST = 2'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_WAIT    = 3'd1,
    S_MAC_DLY = 3'd2,
    S_APP_DLY = 3'd3,
    S_RUN     = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retry_q, retry_d;
  logic          pcs_q, pcs_d, mac_q, mac_d, app_q, app_d;
  logic          ready_q, ready_d, fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (soft_rst_req) begin
      state_d = S_HOLD;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        S_HOLD: if (cnt_q == PCS_LAST) state_d = S_WAIT;
        S_WAIT: begin
          // link_ok in the final timeout cycle still wins over the retry
          if (link_ok) state_d = S_MAC_DLY;
          else if (cnt_q == LINK_LAST) begin
            if (retry_q == RETRY_LAST) state_d = S_FAULT;
            else begin
              retry_d = retry_q + 2'd1;
              state_d = S_HOLD;
            end
          end
        end
        S_MAC_DLY: begin
          if (!link_ok) state_d = S_WAIT;
          else if (cnt_q == MAC_LAST) state_d = S_APP_DLY;
        end
        S_APP_DLY: begin
          if (!link_ok) state_d = S_WAIT;
          else if (cnt_q == APP_LAST) begin
            state_d = S_RUN;
            retry_d = 2'd0;
          end
        end
        S_RUN:   if (!link_ok) state_d = S_WAIT;
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_HOLD;
      endcase
    end

    if (soft_rst_req || (state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAULT))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    // Outputs decode the next state so they flip on the same edge as the state
    pcs_d   = (state_d == S_HOLD) || (state_d == S_FAULT);
    mac_d   = !((state_d == S_APP_DLY) || (state_d == S_RUN));
    app_d   = (state_d != S_RUN);
    ready_d = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      retry_q <= 2'd0;
      pcs_q   <= 1'b1;
      mac_q   <= 1'b1;
      app_q   <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pcs_q   <= pcs_d;
      mac_q   <= mac_d;
      app_q   <= app_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  assign rst_pcs   = pcs_q;
  assign rst_mac   = mac_q;
  assign rst_app   = app_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign seq_state = state_q;
  assign retry_cnt = retry_q;

endmodule
